// File: rtl/cpu_ctrl_pkg.sv
// Shared control package for the pipeline commit/flush logic.
//   - flush_state_e : exception/ERTN flush controller states
//   - ECODE_*       : exception codes written into ESTAT.Ecode
//   - MAX_OUTSTANDING_DEFAULT : default inst-SRAM requests allowed in flight
package cpu_ctrl_pkg;

  localparam int MAX_OUTSTANDING_DEFAULT = 2;

  // Width of the in-flight request counters (holds 0..3).
  localparam int REQ_CNT_W = 2;

  localparam logic [5:0] ECODE_INT = 6'h0;
  localparam logic [5:0] ECODE_PIL = 6'h1;
  localparam logic [5:0] ECODE_PIS = 6'h2;
  localparam logic [5:0] ECODE_PIF = 6'h3;
  localparam logic [5:0] ECODE_PME = 6'h4;
  localparam logic [5:0] ECODE_ADE = 6'h8;
  localparam logic [5:0] ECODE_ALE = 6'h9;
  localparam logic [5:0] ECODE_SYS = 6'hb;
  localparam logic [5:0] ECODE_BRK = 6'hc;
  localparam logic [5:0] ECODE_INE = 6'hd;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } flush_state_e;

endpackage

// File: rtl/exc_flush_ctrl_if.sv
// Signal bundle between the flush controller and the WB stage, CSR file,
// fetch stage and inst-SRAM handshake.
//   master : pipeline side (drives WB/CSR status, SRAM handshake, redirect_ready)
//   slave  : controller side (drives flush, fetch throttling and redirect)
interface exc_flush_ctrl_if;
  logic        ws_valid;
  logic        wb_ex;
  logic        wb_ertn;
  logic [31:0] csr_eentry;
  logic [31:0] csr_era;
  logic        int_pending;
  logic        inst_req;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic        int_take;
  logic        flush;
  logic        stall_fetch;
  logic        inst_req_allow;
  logic        resp_discard;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport master (
    output ws_valid, wb_ex, wb_ertn, csr_eentry, csr_era, int_pending,
           inst_req, inst_addr_ok, inst_data_ok, redirect_ready,
    input  int_take, flush, stall_fetch, inst_req_allow, resp_discard,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  ws_valid, wb_ex, wb_ertn, csr_eentry, csr_era, int_pending,
           inst_req, inst_addr_ok, inst_data_ok, redirect_ready,
    output int_take, flush, stall_fetch, inst_req_allow, resp_discard,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/req_track_cnt.sv
// Saturating up/down counter of outstanding requests.
//   clk, reset : clock, synchronous active-high reset
//   inc, dec   : one request accepted / one response returned this cycle
//   count      : current value
//   count_next : value after this cycle's edge
module req_track_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // inc and dec together cancel; the ends saturate instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count      = cnt_q;
  assign count_next = cnt_d;

endmodule

// File: rtl/exc_flush_ctrl.sv
// Exception/ERTN commit controller. Turns a committing exception or ERTN
// into a single-cycle pipeline flush, drains inst-SRAM responses that belong
// to the squashed path, then offers the fetch stage one redirect PC.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of exc_flush_ctrl_if (WB/CSR status in,
//                flush/int_take/fetch throttle/redirect out)
module exc_flush_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  exc_flush_ctrl_if.slave  bus
);

  localparam logic [REQ_CNT_W-1:0] MAX_CNT = REQ_CNT_W'(MAX_OUTSTANDING);

  flush_state_e          state_q, state_d;
  logic [REQ_CNT_W-1:0]  disc_cnt_q, disc_cnt_d;
  logic [31:0]           target_q, target_d;
  logic [REQ_CNT_W-1:0]  out_cnt;
  logic [REQ_CNT_W-1:0]  out_cnt_next;
  logic                  in_idle;
  logic                  trigger;
  logic                  discard;

  req_track_cnt #(.W(REQ_CNT_W)) u_out_cnt (
    .clk        (clk),
    .reset      (reset),
    .inc        (bus.inst_req & bus.inst_addr_ok),
    .dec        (bus.inst_data_ok),
    .count      (out_cnt),
    .count_next (out_cnt_next)
  );

  assign in_idle = (state_q == IDLE);
  assign trigger = in_idle & (bus.wb_ex | bus.wb_ertn);
  // disc_cnt is only non-zero while draining, so this never fires in IDLE.
  assign discard = bus.inst_data_ok & (disc_cnt_q != '0);

  always_comb begin
    state_d    = state_q;
    disc_cnt_d = disc_cnt_q;
    target_d   = target_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          target_d = bus.wb_ex ? bus.csr_eentry : bus.csr_era;
          // Everything still unanswered after this edge is on the dead path,
          // including a request accepted in the trigger cycle itself.
          disc_cnt_d = out_cnt_next;
          state_d    = (out_cnt_next != '0) ? DRAIN : REDIRECT;
        end
      end
      DRAIN: begin
        if (discard) begin
          disc_cnt_d = disc_cnt_q - 1'b1;
          if (disc_cnt_q == REQ_CNT_W'(1)) begin
            state_d = REDIRECT;
          end
        end
      end
      REDIRECT: begin
        if (bus.redirect_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      disc_cnt_q <= '0;
      target_q   <= '0;
    end else begin
      state_q    <= state_d;
      disc_cnt_q <= disc_cnt_d;
      target_q   <= target_d;
    end
  end

  // ERTN wins over a pending interrupt; the ERTN itself returns to a context
  // where the interrupt is resampled.
  assign bus.int_take       = bus.int_pending & bus.ws_valid & in_idle & ~bus.wb_ertn;
  assign bus.flush          = trigger;
  assign bus.stall_fetch    = ~in_idle;
  assign bus.inst_req_allow = in_idle & (out_cnt < MAX_CNT);
  assign bus.resp_discard   = discard;
  assign bus.redirect_valid = (state_q == REDIRECT);
  assign bus.redirect_pc    = target_q;

endmodule

// File: tb/tb_exc_flush_ctrl.sv
// Testbench for exc_flush_ctrl: a per-cycle vector table run through a
// scoreboard queue, plus hand-written drain sequences with varied gaps.
module tb_exc_flush_ctrl;

  localparam logic [31:0] PC_E   = 32'h1c008000;
  localparam logic [31:0] PC_R   = 32'h1c000104;
  localparam logic [31:0] PC_ALT = 32'h1c009000;

  logic clk;
  logic reset;
  logic alt;

  exc_flush_ctrl_if bus ();

  exc_flush_ctrl #(.MAX_OUTSTANDING(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in  = {rst, ws_valid, wb_ex, wb_ertn, int_pending, inst_req, addr_ok, data_ok, ready, alt_eentry}
  // exp = {int_take, flush, stall_fetch, inst_req_allow, resp_discard, redirect_valid}
  typedef struct {
    string       tag;
    logic [9:0]  in;
    logic [5:0]  exp;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   tests  = 0;
  int   failed = 0;
  int   outst  = 0;

  function automatic logic [31:0] pc_of(input int sel);
    case (sel)
      1:       return PC_E;
      2:       return PC_R;
      3:       return PC_ALT;
      default: return 32'h0;
    endcase
  endfunction

  function automatic vec_t v(input string tag, input logic [9:0] in,
                             input logic [5:0] exp, input int pcsel);
    vec_t r;
    r.tag = tag;
    r.in  = in;
    r.exp = exp;
    r.pc  = pc_of(pcsel);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ws_valid = 0; bus.wb_ex = 0; bus.wb_ertn = 0; bus.int_pending = 0;
    bus.inst_req = 0; bus.inst_addr_ok = 0; bus.inst_data_ok = 0;
    bus.redirect_ready = 0;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    vec_t e;
    logic [5:0] got;
    {reset, bus.ws_valid, bus.wb_ex, bus.wb_ertn, bus.int_pending, bus.inst_req,
     bus.inst_addr_ok, bus.inst_data_ok, bus.redirect_ready, alt} = t.in;
    bus.csr_eentry = alt ? PC_ALT : PC_E;
    bus.csr_era    = PC_R;
    sb.push_back(t);
    @(negedge clk);
    if (bus.inst_data_ok && outst == 0) begin
      failed++;
      $display("FAIL stimulus row %0d (%s): data_ok with no request outstanding", idx, t.tag);
    end
    e   = sb.pop_front();
    got = {bus.int_take, bus.flush, bus.stall_fetch, bus.inst_req_allow,
           bus.resp_discard, bus.redirect_valid};
    tests++;
    if (got !== e.exp || bus.redirect_pc !== e.pc) begin
      failed++;
      $display("FAIL row %0d (%s): got it/fl/st/al/dis/rv=%b pc=%h, expected %b pc=%h",
               idx, e.tag, got, bus.redirect_pc, e.exp, e.pc);
    end else begin
      $display("[TB] row %0d (%s) flags=%b pc=%h ok", idx, e.tag, got, bus.redirect_pc);
    end
    tick();
    if (reset) outst = 0;
    else outst = outst + int'(bus.inst_req & bus.inst_addr_ok) - int'(bus.inst_data_ok);
  endtask

  // Two requests outstanding, ERTN, then both responses with the given gaps.
  task automatic drain_seq(input int gap1, input int gap2, input logic [31:0] era);
    idle_inputs();
    bus.csr_era = era;
    bus.inst_req = 1; bus.inst_addr_ok = 1;
    tick(); tick();
    bus.inst_req = 0; bus.inst_addr_ok = 0;
    bus.wb_ertn = 1;
    @(negedge clk);
    check("drain_trigger_flush", 64'(bus.flush), 64'd1);
    tick();
    bus.wb_ertn = 0;
    repeat (gap1) begin
      @(negedge clk);
      check("drain_wait1", 64'({bus.stall_fetch, bus.redirect_valid, bus.resp_discard}), 64'b100);
      tick();
    end
    bus.inst_data_ok = 1;
    @(negedge clk);
    check("drain_discard1", 64'({bus.stall_fetch, bus.redirect_valid, bus.resp_discard}), 64'b101);
    tick();
    bus.inst_data_ok = 0;
    repeat (gap2) begin
      @(negedge clk);
      check("drain_wait2", 64'({bus.stall_fetch, bus.redirect_valid, bus.resp_discard}), 64'b100);
      tick();
    end
    bus.inst_data_ok = 1;
    @(negedge clk);
    check("drain_discard2", 64'({bus.stall_fetch, bus.redirect_valid, bus.resp_discard}), 64'b101);
    tick();
    bus.inst_data_ok = 0;
    @(negedge clk);
    check("drain_redirect", {29'd0, bus.stall_fetch, bus.redirect_valid, bus.resp_discard, bus.redirect_pc},
          {29'd0, 3'b110, era});
    bus.redirect_ready = 1;
    tick();
    bus.redirect_ready = 0;
    @(negedge clk);
    check("drain_idle", 64'({bus.stall_fetch, bus.inst_req_allow, bus.redirect_valid}), 64'b010);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // quiet exception
    tbl.push_back(v("reset_vals",   10'b0000000000, 6'b000100, 0));
    tbl.push_back(v("quiet_trig",   10'b0110000000, 6'b010100, 0));
    tbl.push_back(v("quiet_redir",  10'b0000000010, 6'b001001, 1));
    tbl.push_back(v("quiet_idle",   10'b0000000000, 6'b000100, 1));
    // ERTN with two outstanding
    tbl.push_back(v("ertn_req1",    10'b0000011000, 6'b000100, 1));
    tbl.push_back(v("ertn_req2",    10'b0000011000, 6'b000100, 1));
    tbl.push_back(v("ertn_full",    10'b0000000000, 6'b000000, 1));
    tbl.push_back(v("ertn_trig",    10'b0001000000, 6'b010000, 1));
    tbl.push_back(v("ertn_t1",      10'b0000000000, 6'b001000, 2));
    tbl.push_back(v("ertn_t2",      10'b0000000000, 6'b001000, 2));
    tbl.push_back(v("ertn_t3_dok",  10'b0000000100, 6'b001010, 2));
    tbl.push_back(v("ertn_t4",      10'b0000000000, 6'b001000, 2));
    tbl.push_back(v("ertn_t5_dok",  10'b0000000100, 6'b001010, 2));
    tbl.push_back(v("ertn_t6_redir",10'b0000000010, 6'b001001, 2));
    tbl.push_back(v("ertn_idle",    10'b0000000000, 6'b000100, 2));
    // simultaneous accept and data_ok on trigger
    tbl.push_back(v("sim_req",      10'b0000011000, 6'b000100, 2));
    tbl.push_back(v("sim_trig",     10'b0010011100, 6'b010100, 2));
    tbl.push_back(v("sim_drain",    10'b0000000000, 6'b001000, 1));
    tbl.push_back(v("sim_disc",     10'b0000000100, 6'b001010, 1));
    tbl.push_back(v("sim_redir_nr", 10'b0000000000, 6'b001001, 1));
    tbl.push_back(v("sim_redir",    10'b0000000010, 6'b001001, 1));
    tbl.push_back(v("sim_newreq",   10'b0000011000, 6'b000100, 1));
    tbl.push_back(v("sim_kept",     10'b0000000100, 6'b000100, 1));
    // interrupt
    tbl.push_back(v("int_take",     10'b0100100000, 6'b100100, 1));
    tbl.push_back(v("int_trig",     10'b0110100000, 6'b110100, 1));
    tbl.push_back(v("int_busy",     10'b0100100000, 6'b001001, 1));
    tbl.push_back(v("int_redir",    10'b0100100010, 6'b001001, 1));
    tbl.push_back(v("int_vs_ertn",  10'b0101100000, 6'b010100, 1));
    tbl.push_back(v("int_ertn_rd",  10'b0000000010, 6'b001001, 2));
    tbl.push_back(v("int_idle",     10'b0000000000, 6'b000100, 2));
    // redirect back-pressure
    tbl.push_back(v("bp_trig",      10'b0010000000, 6'b010100, 2));
    tbl.push_back(v("bp_wait1",     10'b0000000000, 6'b001001, 1));
    tbl.push_back(v("bp_wait2_ex",  10'b0010000001, 6'b001001, 1));
    tbl.push_back(v("bp_wait3_er",  10'b0001000000, 6'b001001, 1));
    tbl.push_back(v("bp_wait4",     10'b0000000001, 6'b001001, 1));
    tbl.push_back(v("bp_accept",    10'b0000000010, 6'b001001, 1));
    tbl.push_back(v("bp_retrig",    10'b0010000001, 6'b010100, 1));
    tbl.push_back(v("bp_redir_alt", 10'b0000000010, 6'b001001, 3));
    tbl.push_back(v("bp_idle",      10'b0000000000, 6'b000100, 3));
    // reset while draining
    tbl.push_back(v("rst_req1",     10'b0000011000, 6'b000100, 3));
    tbl.push_back(v("rst_req2",     10'b0000011000, 6'b000100, 3));
    tbl.push_back(v("rst_trig",     10'b0010000000, 6'b010000, 3));
    tbl.push_back(v("rst_drain",    10'b0000000000, 6'b001000, 1));
    tbl.push_back(v("rst_assert",   10'b1000000000, 6'b001000, 1));
    tbl.push_back(v("rst_cleared",  10'b0000000000, 6'b000100, 0));
    tbl.push_back(v("rst_req_a",    10'b0000011000, 6'b000100, 0));
    tbl.push_back(v("rst_req_b",    10'b0000011000, 6'b000100, 0));
    tbl.push_back(v("rst_full",     10'b0000000000, 6'b000000, 0));
    tbl.push_back(v("rst_dok1",     10'b0000000100, 6'b000000, 0));
    tbl.push_back(v("rst_dok2",     10'b0000000100, 6'b000100, 0));

    idle_inputs();
    alt            = 0;
    bus.csr_eentry = PC_E;
    bus.csr_era    = PC_R;
    reset          = 1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    reset = 0;
    drain_seq(0, 0, 32'h1c000200);
    drain_seq(2, 1, 32'h1c0003f0);
    drain_seq(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              {$urandom_range(0, 32'h3fffffff), 2'b00});

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/exc_flush_ctrl.md
# exc_flush_ctrl

Exception/ERTN commit controller between the write-back stage, the CSR file and the fetch stage of the LoongArch pipeline. It:
- turns a committing exception, ERTN or pending interrupt into one pipeline-wide flush;
- drains in-flight instruction-SRAM responses that belong to the squashed path;
- hands the fetch stage one redirect PC (exception entry or ERA) over a valid/ready handshake;
- tracks outstanding instruction requests and throttles new ones.

## Interface
Parameters
- MAX_OUTSTANDING, 2, maximum inst-SRAM requests in flight (1..3).

Ports
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- ws_valid  in  1  valid instruction present in WB
- wb_ex  in  1  WB commits an exception this cycle (includes interrupt-tagged instruction)
- wb_ertn  in  1  WB commits ERTN this cycle
- csr_eentry  in  32  exception entry address from CSR
- csr_era  in  32  ERA value from CSR
- int_pending  in  1  CSR interrupt request (ESTAT.IS & ECFG.LIE & CRMD.IE already reduced)
- inst_req  in  1  fetch issues inst-SRAM request
- inst_addr_ok  in  1  inst-SRAM accepts request
- inst_data_ok  in  1  inst-SRAM returns data
- int_take  out  1  tag WB instruction as interrupt (WB ORs it into wb_ex, ecode INT)
- flush  out  1  kill all valid bits in IF/ID/EXE/MEM this cycle
- stall_fetch  out  1  fetch must not issue or advance
- inst_req_allow  out  1  fetch may assert inst_req
- resp_discard  out  1  current inst_data_ok belongs to squashed path; fetch drops it
- redirect_valid  out  1  redirect PC offered
- redirect_pc  out  32  redirect target
- redirect_ready  in  1  fetch accepts redirect

## Operation
- State machine with states IDLE, DRAIN, REDIRECT; reset state IDLE.
- Trigger: state==IDLE && (wb_ex | wb_ertn).
  - wb_ex has priority over wb_ertn if both are high.
  - Target latched on the trigger cycle: csr_eentry for exception, csr_era for ERTN.
  - wb_ex/wb_ertn outside IDLE are ignored; stages are already squashed.
- int_take = int_pending & ws_valid & state==IDLE & ~wb_ertn (combinational, no dependence on wb_ex).
- flush = trigger (combinational, single cycle only).
- Outstanding counter `out_cnt`, 2 bits:
  - +1 on inst_req & inst_addr_ok; −1 on inst_data_ok; both in one cycle → unchanged.
  - Never wraps; the bench flags data_ok while out_cnt==0 as an error.
- inst_req_allow = state==IDLE & out_cnt < MAX_OUTSTANDING.
- Discard counter `disc_cnt`:
  - On trigger, loaded with the post-cycle out_cnt value (out_cnt + inc − dec), i.e. every request still unanswered after the trigger edge.
  - resp_discard = inst_data_ok & disc_cnt != 0; each such response decrements disc_cnt.
- Transitions:
  - IDLE → DRAIN on trigger if the loaded disc_cnt != 0, else IDLE → REDIRECT.
  - DRAIN → REDIRECT on the cycle disc_cnt goes 0, i.e. last discarded data_ok.
  - REDIRECT → IDLE when redirect_ready.
- stall_fetch = state != IDLE.
- redirect_valid = state==REDIRECT; redirect_pc holds the latched target and stays stable while valid and not ready.

## Timing
- Reset values: state IDLE, out_cnt 0, disc_cnt 0, redirect_pc 0.
- Outputs at reset: flush, int_take, redirect_valid, resp_discard, stall_fetch all 0; inst_req_allow 1.
- Trigger in cycle T: flush high in T only; stall_fetch high from T+1.
- redirect_valid:
  - With disc_cnt==0, high from T+1.
  - With pending responses, high the cycle after the last discarded data_ok.
- Minimum turnaround, trigger to IDLE with ready held high: 2 cycles.
- A new trigger is accepted in the cycle after REDIRECT handshake completes.
- Reset mid-DRAIN/REDIRECT returns to IDLE next edge; counters clear and no redirect is issued.

## Structure
- Shared package `cpu_ctrl_pkg`:
  - state encodings for IDLE, DRAIN, REDIRECT;
  - ECODE_INT = 6'h0 alongside the existing ecode constants;
  - MAX_OUTSTANDING default.
- One sub-module `req_track_cnt`: saturating up/down outstanding counter with inc, dec and count output. It is instantiated once for out_cnt; disc_cnt logic stays in the top.

## Test plan
- Quiet exception: out_cnt 0, wb_ex at T with csr_eentry 0x1c008000 → flush at T, redirect_valid T+1 with pc 0x1c008000, IDLE at T+2 with ready high.
- ERTN with two outstanding requests: csr_era 0x1c000104, data_ok at T+3 and T+5 → resp_discard on both, redirect_valid from T+6, pc 0x1c000104.
- Simultaneous request accept and data_ok on the trigger cycle with out_cnt 1 → disc_cnt 1, exactly one later response discarded.
- Interrupt: int_pending=1, ws_valid=1 in IDLE → int_take=1 that cycle; WB wb_ex → flush, redirect to csr_eentry; int_take=0 while state != IDLE.
- Redirect back-pressure: redirect_ready low for 4 cycles → redirect_valid and redirect_pc stable; a second wb_ex during the wait is ignored.
- Reset asserted in DRAIN with disc_cnt 2 → next cycle all outputs at reset values, inst_req_allow=1.
